// File: rtl/instruction_issue_unit_if.sv
// Instruction-fetch and data-memory handshake bundle of the issue unit.
// The master side sits in the issue unit; the memories or the bench take the slave side.
interface instruction_issue_unit_if #(
    parameter int PC_WIDTH = 16
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [15:0]         imem_rdata;
    logic                dmem_req;
    logic                dmem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        output dmem_ack
    );
endinterface

// File: rtl/instruction_issue_unit.sv
// Front end of the 16-bit core: fetches into the instruction register, steps the five
// execution phases, and resolves branches from the decoder's PC_load and the SZCV flags.
//
// state | meaning
// IDLE  | waiting for run, no requests
// FETCH | P1, imem_req high until imem_ack, then latch COMMAND and increment pc
// DEC   | P2, detect HLT
// EXE   | P3, single cycle
// MEM   | P4, LD/ST hold dmem_req until dmem_ack, other opcodes pass through
// WB    | P5, branch resolution, then FETCH or IDLE depending on run
// HALT  | halted high, leaves only on a rising edge of run
module instruction_issue_unit #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    instruction_issue_unit_if.master      bus,
    output logic [15:0]                   COMMAND,
    output logic [4:0]                    phase,
    output logic [PC_WIDTH-1:0]           pc,
    input  logic                          PC_load,
    input  logic [3:0]                    SZCV,
    input  logic [PC_WIDTH-1:0]           branch_target,
    output logic                          halted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DEC   = 3'd2,
        ST_EXE   = 3'd3,
        ST_MEM   = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_P1   = 5'b00001;
    localparam logic [4:0] PH_P2   = 5'b00010;
    localparam logic [4:0] PH_P3   = 5'b00100;
    localparam logic [4:0] PH_P4   = 5'b01000;
    localparam logic [4:0] PH_P5   = 5'b10000;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         cmd_q, cmd_d;
    logic [4:0]          phase_q, phase_d;
    logic                imem_req_q, imem_req_d;
    logic                dmem_req_q, dmem_req_d;
    logic                halted_q, halted_d;
    logic                run_q, run_d;

    logic flag_s, flag_z, flag_v;
    logic unused_flag_c;
    logic is_hlt, is_ldst, is_b, is_bcond, cond_met, branch_taken;

    assign flag_s        = SZCV[3];
    assign flag_z        = SZCV[2];
    assign unused_flag_c = SZCV[1];
    assign flag_v        = SZCV[0];

    // Opcode classes are taken from the instruction register, which is stable after FETCH.
    assign is_hlt    = (cmd_q[15:14] == 2'b11) && (cmd_q[7:4] == 4'b1111);
    assign is_ldst   = (cmd_q[15:14] == 2'b00) || (cmd_q[15:14] == 2'b01);
    assign is_b      = (cmd_q[15:11] == 5'b10100);
    assign is_bcond  = (cmd_q[15:11] == 5'b10111);

    always_comb begin
        cond_met = 1'b0;
        case (cmd_q[10:8])
            3'b000:  cond_met = flag_z;
            3'b001:  cond_met = flag_s ^ flag_v;
            3'b010:  cond_met = flag_z | (flag_s ^ flag_v);
            3'b011:  cond_met = ~flag_z;
            default: cond_met = 1'b0;
        endcase
    end

    assign branch_taken = PC_load && (is_b || (is_bcond && cond_met));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cmd_d   = cmd_q;
        run_d   = run;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack && imem_req_q) begin
                    cmd_d   = bus.imem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_DEC;
                end
            end
            ST_DEC: begin
                state_d = is_hlt ? ST_HALT : ST_EXE;
            end
            ST_EXE: begin
                state_d = ST_MEM;
            end
            ST_MEM: begin
                if (!is_ldst || (bus.dmem_ack && dmem_req_q)) state_d = ST_WB;
            end
            ST_WB: begin
                // pc was already incremented in FETCH; a taken branch simply overwrites it.
                if (branch_taken) pc_d = branch_target;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                if (run && !run_q) state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        phase_d    = PH_NONE;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        halted_d   = 1'b0;
        case (state_d)
            ST_FETCH: begin
                phase_d    = PH_P1;
                imem_req_d = 1'b1;
            end
            ST_DEC:  phase_d = PH_P2;
            ST_EXE:  phase_d = PH_P3;
            ST_MEM: begin
                phase_d    = PH_P4;
                dmem_req_d = is_ldst;
            end
            ST_WB:   phase_d = PH_P5;
            ST_HALT: halted_d = 1'b1;
            default: phase_d = PH_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            cmd_q      <= 16'h0000;
            phase_q    <= PH_NONE;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            halted_q   <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cmd_q      <= cmd_d;
            phase_q    <= phase_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            halted_q   <= halted_d;
            run_q      <= run_d;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign COMMAND       = cmd_q;
    assign phase         = phase_q;
    assign pc            = pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Directed bench for instruction_issue_unit: fetch stepping, LD stall, branch
// resolution, HLT/resume and asynchronous reset during handshakes.
module tb_instruction_issue_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] COMMAND;
    logic [4:0]  phase;
    logic [15:0] pc;
    logic        PC_load;
    logic [3:0]  SZCV;
    logic [15:0] branch_target;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_issue_unit_if #(.PC_WIDTH(16)) bus_if ();

    instruction_issue_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .bus           (bus_if),
        .COMMAND       (COMMAND),
        .phase         (phase),
        .pc            (pc),
        .PC_load       (PC_load),
        .SZCV          (SZCV),
        .branch_target (branch_target),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        run                = 1'b0;
        bus_if.imem_ack    = 1'b0;
        bus_if.imem_rdata  = 16'h0000;
        bus_if.dmem_ack    = 1'b0;
        PC_load            = 1'b0;
        SZCV               = 4'b0000;
        branch_target      = 16'h0000;
        rst_n              = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_fetch(input logic [15:0] addr, output bit found);
        found = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (bus_if.imem_req && bus_if.imem_addr == addr) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        run               = 1'b0;
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 16'h0000;
        bus_if.dmem_ack   = 1'b0;
        PC_load           = 1'b0;
        SZCV              = 4'b0000;
        branch_target     = 16'h0000;
        rst_n             = 1'b0;
        #3;
        n_checks++;
        if ({bus_if.imem_req, bus_if.dmem_req, halted, phase} !== 8'h00)
            $display("FAIL reset_ctrl: got req/dreq/halt/phase=%b expected 00000000",
                     {bus_if.imem_req, bus_if.dmem_req, halted, phase});
        else n_pass++;
        n_checks++;
        if (pc !== 16'h0000 || COMMAND !== 16'h0000)
            $display("FAIL reset_regs: got pc=%h cmd=%h expected 0000/0000", pc, COMMAND);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus_if.imem_req !== 1'b0)
            $display("FAIL idle_no_run: got imem_req=%b expected 0", bus_if.imem_req);
        else n_pass++;
    endtask

    task automatic test_fetch_sequence();
        do_reset();
        bus_if.imem_rdata = 16'hC040;
        bus_if.imem_ack   = 1'b1;
        run               = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            logic [4:0] exp_ph;
            exp_ph = 5'b00001 << (i % 5);
            n_checks++;
            if (phase !== exp_ph)
                $display("FAIL seq_phase[%0d]: got %b expected %b", i, phase, exp_ph);
            else n_pass++;
            n_checks++;
            if (bus_if.dmem_req !== 1'b0)
                $display("FAIL seq_dmem[%0d]: got dmem_req=%b expected 0", i, bus_if.dmem_req);
            else n_pass++;
            if (i % 5 == 0) begin
                n_checks++;
                if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 16'(i / 5))
                    $display("FAIL seq_fetch[%0d]: got req=%b addr=%h expected 1/%h",
                             i, bus_if.imem_req, bus_if.imem_addr, 16'(i / 5));
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_ld_stall();
        int len;
        do_reset();
        bus_if.imem_rdata = 16'h0105;
        bus_if.imem_ack   = 1'b1;
        run               = 1'b1;
        step();
        len = 0;
        n_checks++;
        if (phase !== 5'b00001 || bus_if.imem_addr !== 16'h0000)
            $display("FAIL ld_fetch: got phase=%b addr=%h expected 00001/0000",
                     phase, bus_if.imem_addr);
        else n_pass++;
        // count from this FETCH until the next FETCH, raising dmem_ack on the 4th MEM cycle
        for (int k = 0; k < 30; k++) begin
            step();
            len++;
            if (phase == 5'b01000) begin
                n_checks++;
                if (bus_if.dmem_req !== 1'b1)
                    $display("FAIL ld_dmem_req: got %b expected 1 in MEM cycle %0d",
                             bus_if.dmem_req, len);
                else n_pass++;
                bus_if.dmem_ack = (len == 6);
            end else begin
                bus_if.dmem_ack = 1'b0;
            end
            if (phase == 5'b10000) begin
                n_checks++;
                if (pc !== 16'h0001 || bus_if.dmem_req !== 1'b0)
                    $display("FAIL ld_wb: got pc=%h dmem_req=%b expected 0001/0",
                             pc, bus_if.dmem_req);
                else n_pass++;
            end
            if (phase == 5'b00001) break;
        end
        n_checks++;
        if (len !== 8)
            $display("FAIL ld_length: got %0d cycles expected 8", len);
        else n_pass++;
        n_checks++;
        if (bus_if.imem_addr !== 16'h0001)
            $display("FAIL ld_next_fetch: got addr=%h expected 0001", bus_if.imem_addr);
        else n_pass++;
    endtask

    task automatic run_branch(input string name, input logic [15:0] cmd, input logic ld,
                              input logic [3:0] flags, input logic [15:0] exp_addr);
        bit found;
        do_reset();
        bus_if.imem_rdata = 16'hC040;
        bus_if.imem_ack   = 1'b1;
        run               = 1'b1;
        wait_fetch(16'h0004, found);
        n_checks++;
        if (!found) begin
            $display("FAIL %s_reach_pc4: got no fetch at 0004 expected one", name);
            return;
        end
        n_pass++;
        bus_if.imem_rdata = cmd;
        PC_load           = ld;
        SZCV              = flags;
        branch_target     = 16'h0020;
        step();
        step();
        step();
        step();
        n_checks++;
        if (phase !== 5'b10000 || pc !== 16'h0005)
            $display("FAIL %s_wb: got phase=%b pc=%h expected 10000/0005", name, phase, pc);
        else n_pass++;
        bus_if.imem_rdata = 16'hC040;
        step();
        n_checks++;
        if (bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== exp_addr)
            $display("FAIL %s_target: got req=%b addr=%h expected 1/%h",
                     name, bus_if.imem_req, bus_if.imem_addr, exp_addr);
        else n_pass++;
        PC_load = 1'b0;
    endtask

    task automatic test_branches();
        run_branch("be_taken",    16'hB800, 1'b1, 4'b0100, 16'h0020);
        run_branch("be_not",      16'hB800, 1'b1, 4'b0000, 16'h0005);
        run_branch("blt_taken",   16'hB900, 1'b1, 4'b1000, 16'h0020);
        run_branch("blt_not",     16'hB900, 1'b1, 4'b1001, 16'h0005);
        run_branch("ble_taken",   16'hBA00, 1'b1, 4'b0100, 16'h0020);
        run_branch("bne_not",     16'hBB00, 1'b1, 4'b0100, 16'h0005);
        run_branch("cond100",     16'hBC00, 1'b1, 4'b1111, 16'h0005);
        run_branch("b_uncond",    16'hA000, 1'b1, 4'b0000, 16'h0020);
        run_branch("b_no_pcload", 16'hA000, 1'b0, 4'b0000, 16'h0005);
    endtask

    task automatic test_halt();
        bit found;
        do_reset();
        bus_if.imem_rdata = 16'hC040;
        bus_if.imem_ack   = 1'b1;
        run               = 1'b1;
        wait_fetch(16'h0002, found);
        n_checks++;
        if (!found) begin
            $display("FAIL hlt_reach_pc2: got no fetch at 0002 expected one");
            return;
        end
        n_pass++;
        bus_if.imem_rdata = 16'hC0F0;
        step();
        n_checks++;
        if (phase !== 5'b00010 || COMMAND !== 16'hC0F0)
            $display("FAIL hlt_dec: got phase=%b cmd=%h expected 00010/c0f0", phase, COMMAND);
        else n_pass++;
        bus_if.imem_rdata = 16'hC040;
        step();
        n_checks++;
        if ({halted, phase, bus_if.imem_req} !== 7'b1000000 || pc !== 16'h0003)
            $display("FAIL hlt_enter: got halted/phase/req=%b pc=%h expected 1000000/0003",
                     {halted, phase, bus_if.imem_req}, pc);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (halted !== 1'b1 || bus_if.imem_req !== 1'b0)
            $display("FAIL hlt_stay: got halted=%b req=%b expected 1/0", halted, bus_if.imem_req);
        else n_pass++;
        run = 1'b0;
        step();
        n_checks++;
        if (halted !== 1'b1)
            $display("FAIL hlt_run_low: got halted=%b expected 1", halted);
        else n_pass++;
        run = 1'b1;
        step();
        n_checks++;
        if (halted !== 1'b0 || bus_if.imem_req !== 1'b1 || bus_if.imem_addr !== 16'h0003)
            $display("FAIL hlt_resume: got halted=%b req=%b addr=%h expected 0/1/0003",
                     halted, bus_if.imem_req, bus_if.imem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        bus_if.imem_rdata = 16'hC040;
        bus_if.imem_ack   = 1'b0;
        run               = 1'b1;
        step();
        step();
        n_checks++;
        if (bus_if.imem_req !== 1'b1)
            $display("FAIL rstf_pre: got imem_req=%b expected 1", bus_if.imem_req);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.imem_req !== 1'b0 || phase !== 5'b00000)
            $display("FAIL rstf_drop: got req=%b phase=%b expected 0/00000",
                     bus_if.imem_req, phase);
        else n_pass++;
        run = 1'b0;
        @(negedge clk);
        rst_n           = 1'b1;
        bus_if.imem_ack = 1'b1;
        step();
        step();
        n_checks++;
        if (bus_if.imem_req !== 1'b0 || COMMAND !== 16'h0000 || pc !== 16'h0000)
            $display("FAIL rstf_late_ack: got req=%b cmd=%h pc=%h expected 0/0000/0000",
                     bus_if.imem_req, COMMAND, pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        bus_if.imem_rdata = 16'h0105;
        bus_if.imem_ack   = 1'b1;
        run               = 1'b1;
        step();
        step();
        step();
        step();
        n_checks++;
        if (bus_if.dmem_req !== 1'b1 || COMMAND !== 16'h0105)
            $display("FAIL rstm_pre: got dmem_req=%b cmd=%h expected 1/0105",
                     bus_if.dmem_req, COMMAND);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.dmem_req !== 1'b0 || COMMAND !== 16'h0000 || pc !== 16'h0000)
            $display("FAIL rstm_drop: got dmem_req=%b cmd=%h pc=%h expected 0/0000/0000",
                     bus_if.dmem_req, COMMAND, pc);
        else n_pass++;
        run             = 1'b0;
        bus_if.imem_ack = 1'b0;
        @(negedge clk);
        rst_n           = 1'b1;
        bus_if.dmem_ack = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus_if.dmem_req, bus_if.imem_req, phase} !== 7'b0000000 || pc !== 16'h0000)
            $display("FAIL rstm_late_ack: got dreq/req/phase=%b pc=%h expected 0000000/0000",
                     {bus_if.dmem_req, bus_if.imem_req, phase}, pc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fetch_sequence();
        test_ld_stall();
        test_branches();
        test_halt();
        test_reset_mid_fetch();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
